// File: rtl/tenthirty_table.sv
// Ten-and-a-half table engine: N player seats plus an automatic dealer seat,
// with a req/vld card source, per-round comparison and multi-round tallies.
module tenthirty_table #(
    parameter int NUM_PLAYERS     = 2,
    parameter int MAX_CARDS       = 5,
    parameter int ROUNDS          = 4,
    parameter int LIMIT_HALF      = 21,
    parameter int DEALER_HIT_HALF = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       hit,
    input  logic                       stand,
    output logic                       card_req,
    input  logic                       card_vld,
    input  logic [3:0]                 card_val,
    output logic [2:0]                 state_o,
    output logic [2:0]                 active_seat,
    input  logic [2:0]                 rd_seat,
    output logic [6:0]                 rd_total,
    output logic [2:0]                 rd_count,
    output logic                       result_vld,
    output logic [NUM_PLAYERS-1:0]     win,
    output logic [4*NUM_PLAYERS-1:0]   wins_tally,
    output logic [3:0]                 round_o,
    output logic                       game_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEAL    = 3'd1,
        S_PLAY    = 3'd2,
        S_FETCH   = 3'd3,
        S_DEALER  = 3'd4,
        S_COMPARE = 3'd5,
        S_RESULT  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [2:0] DEALER_SEAT = 3'(NUM_PLAYERS);

    state_t                            state_reg, state_next;
    logic [2:0]                        active_reg, active_next;
    logic                              req_reg, req_next;
    logic [NUM_PLAYERS:0][6:0]         total_reg, total_next;
    logic [NUM_PLAYERS:0][2:0]         count_reg, count_next;
    logic [NUM_PLAYERS-1:0]            win_reg, win_next;
    logic [NUM_PLAYERS-1:0][3:0]       tally_reg, tally_next;
    logic [3:0]                        round_reg, round_next;

    logic                              legal;
    logic                              accept;
    logic [6:0]                        card_pts;
    logic [6:0]                        cur_total;
    logic [2:0]                        cur_count;
    logic [6:0]                        new_total;
    logic [2:0]                        new_count;
    logic                              hand_closed;
    logic [2:0]                        next_seat;
    logic [NUM_PLAYERS-1:0]            player_bust;
    logic [NUM_PLAYERS-1:0]            win_calc;
    logic                              dealer_bust;
    logic                              all_bust;
    logic                              dealer_draws;

    // Face cards are worth half a point; out-of-range ranks are never accepted.
    assign legal    = (card_val >= 4'd1) && (card_val <= 4'd13);
    assign card_pts = (card_val <= 4'd10) ? {2'b00, card_val, 1'b0} : 7'd1;
    assign accept   = req_reg & card_vld & legal;

    always_comb begin
        cur_total = '0;
        cur_count = '0;
        for (int i = 0; i <= NUM_PLAYERS; i++) begin
            if (active_reg == 3'(i)) begin
                cur_total = total_reg[i];
                cur_count = count_reg[i];
            end
        end
    end

    assign new_total   = cur_total + card_pts;
    assign new_count   = cur_count + 3'd1;
    assign hand_closed = (new_total >= 7'(LIMIT_HALF)) || (new_count == 3'(MAX_CARDS));
    assign next_seat   = active_reg + 3'd1;

    assign dealer_bust  = total_reg[NUM_PLAYERS] > 7'(LIMIT_HALF);
    assign all_bust     = &player_bust;
    assign dealer_draws = (total_reg[NUM_PLAYERS] < 7'(DEALER_HIT_HALF)) &&
                          (count_reg[NUM_PLAYERS] < 3'(MAX_CARDS));

    // Ties and double busts both fall to the dealer.
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_seat
        assign player_bust[gi] = total_reg[gi] > 7'(LIMIT_HALF);
        assign win_calc[gi]    = !player_bust[gi] &&
                                 (dealer_bust || (total_reg[gi] > total_reg[NUM_PLAYERS]));
    end

    always_comb begin
        state_next  = state_reg;
        active_next = active_reg;
        req_next    = req_reg;
        total_next  = total_reg;
        count_next  = count_reg;
        win_next    = win_reg;
        tally_next  = tally_reg;
        round_next  = round_reg;

        if (accept) begin
            req_next = 1'b0;
            for (int i = 0; i <= NUM_PLAYERS; i++) begin
                if (active_reg == 3'(i)) begin
                    total_next[i] = new_total;
                    count_next[i] = new_count;
                end
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next  = S_DEAL;
                    active_next = 3'd0;
                    req_next    = 1'b1;
                    total_next  = '0;
                    count_next  = '0;
                    win_next    = '0;
                    tally_next  = '0;
                    round_next  = '0;
                end
            end
            S_DEAL: begin
                if (accept) begin
                    if (active_reg == DEALER_SEAT) begin
                        state_next  = S_PLAY;
                        active_next = 3'd0;
                    end else begin
                        active_next = next_seat;
                    end
                end else if (!req_reg) begin
                    req_next = 1'b1;
                end
            end
            S_PLAY: begin
                if (stand) begin
                    active_next = next_seat;
                    state_next  = (next_seat == DEALER_SEAT) ? S_DEALER : S_PLAY;
                end else if (hit) begin
                    state_next = S_FETCH;
                    req_next   = 1'b1;
                end
            end
            S_FETCH: begin
                if (accept) begin
                    if (hand_closed) begin
                        active_next = next_seat;
                        state_next  = (next_seat == DEALER_SEAT) ? S_DEALER : S_PLAY;
                    end else begin
                        state_next = S_PLAY;
                    end
                end
            end
            S_DEALER: begin
                // Decide only while idle on the handshake so each new card is seen first.
                if (!accept && !req_reg) begin
                    if (all_bust || !dealer_draws) begin
                        state_next = S_COMPARE;
                    end else begin
                        req_next = 1'b1;
                    end
                end
            end
            S_COMPARE: begin
                win_next   = win_calc;
                round_next = round_reg + 4'd1;
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    tally_next[i] = tally_reg[i] + {3'b000, win_calc[i]};
                end
                state_next = S_RESULT;
            end
            S_RESULT: begin
                if (start) begin
                    if (round_reg < 4'(ROUNDS)) begin
                        state_next  = S_DEAL;
                        active_next = 3'd0;
                        req_next    = 1'b1;
                        total_next  = '0;
                        count_next  = '0;
                        win_next    = '0;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_next  = S_IDLE;
                    active_next = 3'd0;
                    total_next  = '0;
                    count_next  = '0;
                    win_next    = '0;
                    tally_next  = '0;
                    round_next  = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            active_reg <= '0;
            req_reg    <= 1'b0;
            total_reg  <= '0;
            count_reg  <= '0;
            win_reg    <= '0;
            tally_reg  <= '0;
            round_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            active_reg <= active_next;
            req_reg    <= req_next;
            total_reg  <= total_next;
            count_reg  <= count_next;
            win_reg    <= win_next;
            tally_reg  <= tally_next;
            round_reg  <= round_next;
        end
    end

    always_comb begin
        rd_total = '0;
        rd_count = '0;
        for (int i = 0; i <= NUM_PLAYERS; i++) begin
            if (rd_seat == 3'(i)) begin
                rd_total = total_reg[i];
                rd_count = count_reg[i];
            end
        end
    end

    assign state_o     = state_reg;
    assign active_seat = active_reg;
    assign card_req    = req_reg;
    assign result_vld  = (state_reg == S_RESULT);
    assign game_done   = (state_reg == S_DONE);
    assign win         = win_reg;
    assign wins_tally  = tally_reg;
    assign round_o     = round_reg;

endmodule

// File: tb/tb_tenthirty_table.sv
// Directed-vector bench for tenthirty_table: a scripted game table plus
// hand-written sequences for the tally game and the asynchronous reset.
module tb_tenthirty_table;

    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          hit = 1'b0;
    logic          stand = 1'b0;
    logic          card_vld = 1'b0;
    logic [3:0]    card_val = 4'd0;
    logic [2:0]    rd_seat = 3'd0;
    logic          card_req;
    logic [2:0]    state_o;
    logic [2:0]    active_seat;
    logic [6:0]    rd_total;
    logic [2:0]    rd_count;
    logic          result_vld;
    logic [NP-1:0] win;
    logic [4*NP-1:0] wins_tally;
    logic [3:0]    round_o;
    logic          game_done;

    int n_vec = 0;
    int n_bad = 0;

    tenthirty_table #(
        .NUM_PLAYERS(NP), .MAX_CARDS(5), .ROUNDS(4), .LIMIT_HALF(21), .DEALER_HIT_HALF(14)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .stand(stand),
        .card_req(card_req), .card_vld(card_vld), .card_val(card_val),
        .state_o(state_o), .active_seat(active_seat), .rd_seat(rd_seat),
        .rd_total(rd_total), .rd_count(rd_count), .result_vld(result_vld),
        .win(win), .wins_tally(wins_tally), .round_o(round_o), .game_done(game_done)
    );

    always #5 clk = ~clk;

    typedef enum int {A_START, A_CARD, A_HIT, A_STAND, A_HS, A_WAIT} act_t;

    typedef struct {
        act_t       act;
        logic [3:0] arg;
        logic [2:0] st;
        logic [2:0] seat;
        logic [2:0] chk;
        logic [6:0] tot;
        logic [2:0] cnt;
        logic       req;
        logic [1:0] win;
        logic [3:0] rnd;
        logic [7:0] tal;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_play(input logic h, input logic s);
        hit = h; stand = s; @(negedge clk); hit = 1'b0; stand = 1'b0;
    endtask

    task automatic feed(input logic [3:0] v);
        int n;
        n = 0;
        while (!card_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!card_req) check("card_req_timeout", 32'(card_req), 32'd1);
        card_vld = 1'b1;
        card_val = v;
        @(negedge clk);
        card_vld = 1'b0;
        card_val = 4'd0;
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n;
        n = 0;
        while (state_o != s && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (state_o != s) check("state_timeout", 32'(state_o), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g2_cards [4];
        logic [3:0] g2_wins  [4];

        // act, arg, state, seat, chk_seat, total, count, req, win, round, tally
        // Round 1: 3,12,5 dealt, both stand, dealer 10 draws 4 -> 18
        vecs.push_back('{A_START, 4'd0,  3'd1, 3'd0, 3'd0, 7'd0,  3'd0, 1'b1, 2'b00, 4'd0, 8'h00});
        vecs.push_back('{A_CARD,  4'd3,  3'd1, 3'd1, 3'd0, 7'd6,  3'd1, 1'b0, 2'b00, 4'd0, 8'h00});
        vecs.push_back('{A_CARD,  4'd12, 3'd1, 3'd2, 3'd1, 7'd1,  3'd1, 1'b0, 2'b00, 4'd0, 8'h00});
        vecs.push_back('{A_CARD,  4'd5,  3'd2, 3'd0, 3'd2, 7'd10, 3'd1, 1'b0, 2'b00, 4'd0, 8'h00});
        vecs.push_back('{A_STAND, 4'd0,  3'd2, 3'd1, 3'd0, 7'd6,  3'd1, 1'b0, 2'b00, 4'd0, 8'h00});
        vecs.push_back('{A_STAND, 4'd0,  3'd4, 3'd2, 3'd2, 7'd10, 3'd1, 1'b0, 2'b00, 4'd0, 8'h00});
        vecs.push_back('{A_CARD,  4'd4,  3'd4, 3'd2, 3'd2, 7'd18, 3'd2, 1'b0, 2'b00, 4'd0, 8'h00});
        vecs.push_back('{A_WAIT,  4'd6,  3'd6, 3'd2, 3'd1, 7'd1,  3'd1, 1'b0, 2'b00, 4'd1, 8'h00});
        // Round 2: seat0 busts on a hit, stand ignored in FETCH, hit+stand = stand, dealer busts
        vecs.push_back('{A_START, 4'd0,  3'd1, 3'd0, 3'd0, 7'd0,  3'd0, 1'b1, 2'b00, 4'd1, 8'h00});
        vecs.push_back('{A_CARD,  4'd3,  3'd1, 3'd1, 3'd0, 7'd6,  3'd1, 1'b0, 2'b00, 4'd1, 8'h00});
        vecs.push_back('{A_CARD,  4'd9,  3'd1, 3'd2, 3'd1, 7'd18, 3'd1, 1'b0, 2'b00, 4'd1, 8'h00});
        vecs.push_back('{A_CARD,  4'd6,  3'd2, 3'd0, 3'd2, 7'd12, 3'd1, 1'b0, 2'b00, 4'd1, 8'h00});
        vecs.push_back('{A_HIT,   4'd0,  3'd3, 3'd0, 3'd0, 7'd6,  3'd1, 1'b1, 2'b00, 4'd1, 8'h00});
        vecs.push_back('{A_STAND, 4'd0,  3'd3, 3'd0, 3'd0, 7'd6,  3'd1, 1'b1, 2'b00, 4'd1, 8'h00});
        vecs.push_back('{A_CARD,  4'd10, 3'd2, 3'd1, 3'd0, 7'd26, 3'd2, 1'b0, 2'b00, 4'd1, 8'h00});
        vecs.push_back('{A_HS,    4'd0,  3'd4, 3'd2, 3'd1, 7'd18, 3'd1, 1'b0, 2'b00, 4'd1, 8'h00});
        vecs.push_back('{A_CARD,  4'd10, 3'd4, 3'd2, 3'd2, 7'd32, 3'd2, 1'b0, 2'b00, 4'd1, 8'h00});
        vecs.push_back('{A_WAIT,  4'd6,  3'd6, 3'd2, 3'd2, 7'd32, 3'd2, 1'b0, 2'b10, 4'd2, 8'h10});
        // Round 3: seat0 reaches exactly 21 and auto-advances, dealer 21 ties
        vecs.push_back('{A_START, 4'd0,  3'd1, 3'd0, 3'd2, 7'd0,  3'd0, 1'b1, 2'b00, 4'd2, 8'h10});
        vecs.push_back('{A_CARD,  4'd10, 3'd1, 3'd1, 3'd0, 7'd20, 3'd1, 1'b0, 2'b00, 4'd2, 8'h10});
        vecs.push_back('{A_CARD,  4'd2,  3'd1, 3'd2, 3'd1, 7'd4,  3'd1, 1'b0, 2'b00, 4'd2, 8'h10});
        vecs.push_back('{A_CARD,  4'd12, 3'd2, 3'd0, 3'd2, 7'd1,  3'd1, 1'b0, 2'b00, 4'd2, 8'h10});
        vecs.push_back('{A_HIT,   4'd0,  3'd3, 3'd0, 3'd0, 7'd20, 3'd1, 1'b1, 2'b00, 4'd2, 8'h10});
        vecs.push_back('{A_CARD,  4'd11, 3'd2, 3'd1, 3'd0, 7'd21, 3'd2, 1'b0, 2'b00, 4'd2, 8'h10});
        vecs.push_back('{A_HIT,   4'd0,  3'd3, 3'd1, 3'd1, 7'd4,  3'd1, 1'b1, 2'b00, 4'd2, 8'h10});
        vecs.push_back('{A_CARD,  4'd3,  3'd2, 3'd1, 3'd1, 7'd10, 3'd2, 1'b0, 2'b00, 4'd2, 8'h10});
        vecs.push_back('{A_STAND, 4'd0,  3'd4, 3'd2, 3'd2, 7'd1,  3'd1, 1'b0, 2'b00, 4'd2, 8'h10});
        vecs.push_back('{A_CARD,  4'd10, 3'd4, 3'd2, 3'd2, 7'd21, 3'd2, 1'b0, 2'b00, 4'd2, 8'h10});
        vecs.push_back('{A_WAIT,  4'd6,  3'd6, 3'd2, 3'd0, 7'd21, 3'd2, 1'b0, 2'b00, 4'd3, 8'h10});
        // Round 4: illegal ranks 0 and 15 discarded, five-card auto-stand, then DONE and IDLE
        vecs.push_back('{A_START, 4'd0,  3'd1, 3'd0, 3'd0, 7'd0,  3'd0, 1'b1, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_CARD,  4'd1,  3'd1, 3'd1, 3'd0, 7'd2,  3'd1, 1'b0, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_CARD,  4'd0,  3'd1, 3'd1, 3'd1, 7'd0,  3'd0, 1'b1, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_CARD,  4'd15, 3'd1, 3'd1, 3'd1, 7'd0,  3'd0, 1'b1, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_CARD,  4'd7,  3'd1, 3'd2, 3'd1, 7'd14, 3'd1, 1'b0, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_CARD,  4'd8,  3'd2, 3'd0, 3'd2, 7'd16, 3'd1, 1'b0, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_HIT,   4'd0,  3'd3, 3'd0, 3'd0, 7'd2,  3'd1, 1'b1, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_CARD,  4'd1,  3'd2, 3'd0, 3'd0, 7'd4,  3'd2, 1'b0, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_HIT,   4'd0,  3'd3, 3'd0, 3'd0, 7'd4,  3'd2, 1'b1, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_CARD,  4'd1,  3'd2, 3'd0, 3'd0, 7'd6,  3'd3, 1'b0, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_HIT,   4'd0,  3'd3, 3'd0, 3'd0, 7'd6,  3'd3, 1'b1, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_CARD,  4'd11, 3'd2, 3'd0, 3'd0, 7'd7,  3'd4, 1'b0, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_HIT,   4'd0,  3'd3, 3'd0, 3'd0, 7'd7,  3'd4, 1'b1, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_CARD,  4'd12, 3'd2, 3'd1, 3'd0, 7'd8,  3'd5, 1'b0, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_HIT,   4'd0,  3'd3, 3'd1, 3'd0, 7'd8,  3'd5, 1'b1, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_CARD,  4'd3,  3'd2, 3'd1, 3'd1, 7'd20, 3'd2, 1'b0, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_STAND, 4'd0,  3'd4, 3'd2, 3'd2, 7'd16, 3'd1, 1'b0, 2'b00, 4'd3, 8'h10});
        vecs.push_back('{A_WAIT,  4'd6,  3'd6, 3'd2, 3'd1, 7'd20, 3'd2, 1'b0, 2'b10, 4'd4, 8'h20});
        vecs.push_back('{A_START, 4'd0,  3'd7, 3'd2, 3'd7, 7'd0,  3'd0, 1'b0, 2'b10, 4'd4, 8'h20});
        vecs.push_back('{A_START, 4'd0,  3'd0, 3'd0, 3'd0, 7'd0,  3'd0, 1'b0, 2'b00, 4'd0, 8'h00});

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_req", 32'(card_req), 32'd0);
        check("rst_seat", 32'(active_seat), 32'd0);
        check("rst_result_vld", 32'(result_vld), 32'd0);
        check("rst_game_done", 32'(game_done), 32'd0);
        check("rst_win", 32'(win), 32'd0);
        check("rst_tally", 32'(wins_tally), 32'd0);
        check("rst_round", 32'(round_o), 32'd0);
        for (int s = 0; s <= NP; s++) begin
            rd_seat = 3'(s);
            #1;
            check("rst_total", 32'(rd_total), 32'd0);
            check("rst_count", 32'(rd_count), 32'd0);
        end

        // Scripted game
        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].act)
                A_START: pulse_start();
                A_CARD:  feed(vecs[i].arg);
                A_HIT:   pulse_play(1'b1, 1'b0);
                A_STAND: pulse_play(1'b0, 1'b1);
                A_HS:    pulse_play(1'b1, 1'b1);
                default: wait_state(vecs[i].arg[2:0]);
            endcase
            rd_seat = vecs[i].chk;
            #1;
            check($sformatf("v%0d_state", i), 32'(state_o), 32'(vecs[i].st));
            check($sformatf("v%0d_seat", i), 32'(active_seat), 32'(vecs[i].seat));
            check($sformatf("v%0d_total", i), 32'(rd_total), 32'(vecs[i].tot));
            check($sformatf("v%0d_count", i), 32'(rd_count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_req", i), 32'(card_req), 32'(vecs[i].req));
            check($sformatf("v%0d_win", i), 32'(win), 32'(vecs[i].win));
            check($sformatf("v%0d_round", i), 32'(round_o), 32'(vecs[i].rnd));
            check($sformatf("v%0d_tally", i), 32'(wins_tally), 32'(vecs[i].tal));
            check($sformatf("v%0d_result_vld", i), 32'(result_vld), 32'(vecs[i].st == 3'd6));
            check($sformatf("v%0d_game_done", i), 32'(game_done), 32'(vecs[i].st == 3'd7));
            $display("vec %0d: act=%0d arg=%0d state=%0d seat=%0d rd[%0d]=%0d/%0d",
                     i, vecs[i].act, vecs[i].arg, state_o, active_seat, rd_seat, rd_total, rd_count);
        end

        // Second game: seat0 (20 or 4) against a standing dealer 18, wins three of four
        g2_cards = '{4'd10, 4'd10, 4'd2, 4'd10};
        g2_wins  = '{4'd1, 4'd1, 4'd0, 4'd1};
        for (int r = 0; r < 4; r++) begin
            pulse_start();
            feed(g2_cards[r]);
            feed(4'd2);
            feed(4'd9);
            pulse_play(1'b0, 1'b1);
            pulse_play(1'b0, 1'b1);
            wait_state(3'd6);
            check($sformatf("g2_r%0d_win", r), 32'(win), 32'(g2_wins[r]));
            $display("game2 round %0d: win=%b tally=%h round=%0d", r, win, wins_tally, round_o);
        end
        check("g2_tally_seat0", 32'(wins_tally[3:0]), 32'd3);
        check("g2_tally_seat1", 32'(wins_tally[7:4]), 32'd0);
        check("g2_round", 32'(round_o), 32'd4);
        pulse_start();
        check("g2_game_done", 32'(game_done), 32'd1);
        check("g2_done_tally", 32'(wins_tally[3:0]), 32'd3);
        $display("game2 end: state=%0d game_done=%0d", state_o, game_done);

        // Asynchronous reset in the middle of a FETCH handshake
        pulse_start();
        pulse_start();
        feed(4'd3);
        feed(4'd4);
        feed(4'd5);
        pulse_play(1'b1, 1'b0);
        check("pre_rst_state", 32'(state_o), 32'd3);
        check("pre_rst_req", 32'(card_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        rd_seat = 3'd0;
        #0;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_req", 32'(card_req), 32'd0);
        #1;
        check("async_rst_total", 32'(rd_total), 32'd0);
        $display("async reset: state=%0d card_req=%0d", state_o, card_req);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_state", 32'(state_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
